// File: rtl/socket_pkg.sv
// socket_pkg: types and constants shared by the socket read and write
// controllers.
//   t_wr_state      - controller state (ST_WAIT / ST_PUSH)
//   SOCK_DATA_WIDTH - default data word width
//   SOCK_FRAME_LEN  - default words per frame
//   cnt_width()     - width of a counter covering 0..n-1, at least 1 bit
package socket_pkg;

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_PUSH = 1'b1
    } t_wr_state;

    localparam int SOCK_DATA_WIDTH = 8;
    localparam int SOCK_FRAME_LEN  = 4;

    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/socket_writer_if.sv
// socket_writer_if: upstream word stream plus socket FIFO write port.
//   i_data/i_dv/o_ready         - valid-only upstream stream (no stall)
//   i_full/i_empty              - socket FIFO status
//   o_wr_en/o_wr_data           - registered FIFO write port
// Modports: slave = the writer, master = its environment.
interface socket_writer_if
    import socket_pkg::*;
#(
    parameter int DATA_WIDTH = SOCK_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_dv;
    logic                  o_ready;
    logic                  i_full;
    logic                  i_empty;
    logic                  o_wr_en;
    logic [DATA_WIDTH-1:0] o_wr_data;

    modport slave (
        input  i_data, i_dv, i_full, i_empty,
        output o_ready, o_wr_en, o_wr_data
    );

    modport master (
        output i_data, i_dv, i_full, i_empty,
        input  o_ready, o_wr_en, o_wr_data
    );
endinterface

// File: rtl/socket_writer_counter.sv
// counter: word counter with init and wrap at LAST.
//   i_clk  - clock, rising edge
//   i_rst  - asynchronous active-high reset
//   i_init - synchronous return to 0 (has priority over i_dv)
//   i_dv   - count enable; at LAST the count returns to 0
//   o_cnt  - current count
module counter
    import socket_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int LAST  = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_init,
    input  logic             i_dv,
    output logic [WIDTH-1:0] o_cnt
);
    localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: init clears, enable advances and wraps at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (i_init) begin
            cnt_d = {WIDTH{1'b0}};
        end else if (i_dv) begin
            if (cnt_q == LAST_V) begin
                cnt_d = {WIDTH{1'b0}};
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/socket_writer.sv
// socket_writer: writes an upstream word stream into the socket FIFO in
// frames of FRAME_LEN words, starting a frame only when the FIFO is empty.
//   i_clk, i_rst_n - clock and asynchronous active-low reset
//   bus            - stream + FIFO write port (socket_writer_if.slave)
//   i_clr_err      - synchronous clear of o_overflow (a new drop wins)
//   o_frame_done   - pulse with the last write of a frame
//   o_frame_cnt    - completed frames, wrapping
//   o_overflow     - sticky: a word was offered while not ready
module socket_writer
    import socket_pkg::*;
#(
    parameter int DATA_WIDTH = SOCK_DATA_WIDTH,
    parameter int FRAME_LEN  = SOCK_FRAME_LEN,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    socket_writer_if.slave        bus,
    input  logic                  i_clr_err,
    output logic                  o_frame_done,
    output logic [FCNT_WIDTH-1:0] o_frame_cnt,
    output logic                  o_overflow
);
    localparam int            CW       = cnt_width(FRAME_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    t_wr_state             state_q, state_d;
    logic [CW-1:0]         wcnt_s;
    logic                  ready_s, accept_s, last_s, init_s, rst_s;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  frame_done_q, frame_done_d;
    logic [FCNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                  overflow_q, overflow_d;

    assign rst_s = ~i_rst_n;

    // Handshake decode; the counter is held at 0 whenever not pushing.
    always_comb begin
        if (state_q == ST_PUSH) begin
            ready_s = ~bus.i_full;
        end else begin
            ready_s = 1'b0;
        end
        accept_s = bus.i_dv & ready_s;
        last_s   = accept_s & (wcnt_s == LAST_IDX);
        init_s   = (state_q == ST_WAIT);
    end

    counter #(
        .WIDTH (CW),
        .LAST  (FRAME_LEN - 1)
    ) u_word_cnt (
        .i_clk  (i_clk),
        .i_rst  (rst_s),
        .i_init (init_s),
        .i_dv   (accept_s),
        .o_cnt  (wcnt_s)
    );

    // Next state and next register values for outputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: begin
                // A full-and-empty FIFO cannot happen; guard anyway.
                if (bus.i_empty && !bus.i_full) begin
                    state_d = ST_PUSH;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_PUSH: begin
                if (last_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_PUSH;
                end
            end
            default: state_d = ST_WAIT;
        endcase

        wr_en_d      = accept_s;
        frame_done_d = last_s;

        if (accept_s) begin
            wr_data_d = bus.i_data;
        end else begin
            wr_data_d = wr_data_q;
        end

        if (last_s) begin
            frame_cnt_d = frame_cnt_q + FCNT_WIDTH'(1);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end

        // A new drop in the same cycle as a clear keeps the flag set.
        if (bus.i_dv && !ready_s) begin
            overflow_d = 1'b1;
        end else if (i_clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_WAIT;
            wr_en_q      <= 1'b0;
            wr_data_q    <= {DATA_WIDTH{1'b0}};
            frame_done_q <= 1'b0;
            frame_cnt_q  <= {FCNT_WIDTH{1'b0}};
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.o_ready   = ready_s;
    assign bus.o_wr_en   = wr_en_q;
    assign bus.o_wr_data = wr_data_q;
    assign o_frame_done  = frame_done_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_socket_writer.sv
// tb_socket_writer: directed bench for socket_writer.
//   dut_a: FRAME_LEN=4, FCNT_WIDTH=2 (frames, stalls, drops, reset, wrap)
//   dut_b: FRAME_LEN=2, FCNT_WIDTH=16 (gapped input)
// Accepted words are pushed to a per-DUT queue with the expected frame_done,
// frame count and write cycle; a negedge monitor pops and compares them.
module tb_socket_writer;
    import socket_pkg::*;

    localparam int DW = 8;

    typedef struct {
        logic [7:0] data;
        logic       done;
        int         cnt;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    socket_writer_if #(.DATA_WIDTH(DW)) a_if ();
    socket_writer_if #(.DATA_WIDTH(DW)) b_if ();

    logic        a_clr, a_done, a_ovf;
    logic [1:0]  a_cnt;
    logic        b_clr, b_done, b_ovf;
    logic [15:0] b_cnt;

    socket_writer #(.DATA_WIDTH(DW), .FRAME_LEN(4), .FCNT_WIDTH(2)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .bus(a_if), .i_clr_err(a_clr),
        .o_frame_done(a_done), .o_frame_cnt(a_cnt), .o_overflow(a_ovf)
    );

    socket_writer #(.DATA_WIDTH(DW), .FRAME_LEN(2), .FCNT_WIDTH(16)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b_if), .i_clr_err(b_clr),
        .o_frame_done(b_done), .o_frame_cnt(b_cnt), .o_overflow(b_ovf)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   widx_a = 0, fcnt_a = 0, widx_b = 0, fcnt_b = 0;
    int   wr_cnt_b = 0;
    int   exp_seq[5] = '{1, 2, 3, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_if.i_dv = 1'b0;
        tick();
    endtask

    task automatic idle_b();
        b_if.i_dv = 1'b0;
        tick();
    endtask

    task automatic send_a(input logic [7:0] d, input logic acc);
        exp_t e;
        a_if.i_data = d;
        a_if.i_dv   = 1'b1;
        #1;
        chk("a_ready", {31'd0, a_if.o_ready}, {31'd0, acc});
        if (acc) begin
            e.data = d;
            e.done = (widx_a == 3);
            if (e.done) begin
                widx_a = 0;
                fcnt_a = (fcnt_a + 1) % 4;
            end else begin
                widx_a++;
            end
            e.cnt = fcnt_a;
            e.due = cyc + 1;
            qa.push_back(e);
        end
        tick();
    endtask

    task automatic send_b(input logic [7:0] d, input logic acc);
        exp_t e;
        b_if.i_data = d;
        b_if.i_dv   = 1'b1;
        #1;
        chk("b_ready", {31'd0, b_if.o_ready}, {31'd0, acc});
        if (acc) begin
            e.data = d;
            e.done = (widx_b == 1);
            if (e.done) begin
                widx_b = 0;
                fcnt_b++;
            end else begin
                widx_b++;
            end
            e.cnt = fcnt_b;
            e.due = cyc + 1;
            qb.push_back(e);
        end
        tick();
    endtask

    // Scoreboard for dut_a: every write must match the queue head, on time.
    always @(negedge clk) begin
        exp_t e;
        if (a_if.o_wr_en === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_wr", {31'd0, a_if.o_wr_en}, 32'd0);
            end else begin
                e = qa.pop_front();
                chk("a_wr_data", {24'd0, a_if.o_wr_data}, {24'd0, e.data});
                chk("a_frame_done", {31'd0, a_done}, {31'd0, e.done});
                chk("a_frame_cnt", {30'd0, a_cnt}, e.cnt);
                chk("a_latency", cyc, e.due);
            end
        end else begin
            chk("a_done_no_wr", {31'd0, a_done}, 32'd0);
            if (qa.size() > 0 && qa[0].due <= cyc) begin
                chk("a_missing_wr", {31'd0, a_if.o_wr_en}, 32'd1);
                e = qa.pop_front();
            end
        end
    end

    // Scoreboard for dut_b.
    always @(negedge clk) begin
        exp_t e;
        if (b_if.o_wr_en === 1'b1) begin
            wr_cnt_b++;
            if (qb.size() == 0) begin
                chk("b_unexpected_wr", {31'd0, b_if.o_wr_en}, 32'd0);
            end else begin
                e = qb.pop_front();
                chk("b_wr_data", {24'd0, b_if.o_wr_data}, {24'd0, e.data});
                chk("b_frame_done", {31'd0, b_done}, {31'd0, e.done});
                chk("b_frame_cnt", {16'd0, b_cnt}, e.cnt);
                chk("b_latency", cyc, e.due);
            end
        end else begin
            chk("b_done_no_wr", {31'd0, b_done}, 32'd0);
            if (qb.size() > 0 && qb[0].due <= cyc) begin
                chk("b_missing_wr", {31'd0, b_if.o_wr_en}, 32'd1);
                e = qb.pop_front();
            end
        end
    end

    initial begin
        a_if.i_data = 8'h00; a_if.i_dv = 1'b0; a_if.i_full = 1'b0; a_if.i_empty = 1'b0;
        b_if.i_data = 8'h00; b_if.i_dv = 1'b0; b_if.i_full = 1'b0; b_if.i_empty = 1'b0;
        a_clr = 1'b0; b_clr = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_wr_en", {31'd0, a_if.o_wr_en}, 32'd0);
        chk("rst_wr_data", {24'd0, a_if.o_wr_data}, 32'd0);
        chk("rst_done", {31'd0, a_done}, 32'd0);
        chk("rst_cnt", {30'd0, a_cnt}, 32'd0);
        chk("rst_ovf", {31'd0, a_ovf}, 32'd0);
        chk("rst_ready", {31'd0, a_if.o_ready}, 32'd0);

        // Basic frame A0..A3
        rst_n = 1'b1;
        a_if.i_empty = 1'b1;
        idle_a();
        a_if.i_empty = 1'b0;
        send_a(8'hA0, 1'b1); send_a(8'hA1, 1'b1); send_a(8'hA2, 1'b1); send_a(8'hA3, 1'b1);
        idle_a(); idle_a();
        chk("frame1_cnt", {30'd0, a_cnt}, 32'd1);
        chk("wait_ready", {31'd0, a_if.o_ready}, 32'd0);

        // Drops while waiting for an empty FIFO
        send_a(8'h55, 1'b0);
        chk("ovf_set", {31'd0, a_ovf}, 32'd1);
        idle_a();
        chk("ovf_sticky", {31'd0, a_ovf}, 32'd1);
        a_clr = 1'b1; idle_a(); a_clr = 1'b0;
        chk("ovf_clr", {31'd0, a_ovf}, 32'd0);
        a_clr = 1'b1; send_a(8'h66, 1'b0); a_clr = 1'b0;
        chk("ovf_set_wins", {31'd0, a_ovf}, 32'd1);
        a_clr = 1'b1; idle_a(); a_clr = 1'b0;
        chk("ovf_clr2", {31'd0, a_ovf}, 32'd0);

        // FIFO full for 3 cycles after word 2
        a_if.i_empty = 1'b1; idle_a(); a_if.i_empty = 1'b0;
        send_a(8'hB0, 1'b1); send_a(8'hB1, 1'b1);
        a_if.i_full = 1'b1;
        send_a(8'hC0, 1'b0); send_a(8'hC1, 1'b0); send_a(8'hC2, 1'b0);
        a_if.i_full = 1'b0;
        send_a(8'hB2, 1'b1); send_a(8'hB3, 1'b1);
        idle_a();
        chk("stall_ovf", {31'd0, a_ovf}, 32'd1);
        chk("stall_cnt", {30'd0, a_cnt}, 32'd2);
        a_clr = 1'b1; idle_a(); a_clr = 1'b0;

        // Reset mid-frame
        a_if.i_empty = 1'b1; idle_a(); a_if.i_empty = 1'b0;
        send_a(8'hD0, 1'b1); send_a(8'hD1, 1'b1);
        idle_a();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", {31'd0, a_if.o_wr_en}, 32'd0);
        chk("mid_rst_wr_data", {24'd0, a_if.o_wr_data}, 32'd0);
        chk("mid_rst_cnt", {30'd0, a_cnt}, 32'd0);
        chk("mid_rst_ready", {31'd0, a_if.o_ready}, 32'd0);
        widx_a = 0; fcnt_a = 0;
        tick();
        rst_n = 1'b1;
        a_if.i_empty = 1'b1; idle_a(); a_if.i_empty = 1'b0;
        send_a(8'hE0, 1'b1); send_a(8'hE1, 1'b1); send_a(8'hE2, 1'b1); send_a(8'hE3, 1'b1);
        idle_a();
        chk("post_rst_cnt", {30'd0, a_cnt}, 32'd1);

        // Frame counter wrap with a 2-bit counter
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        widx_a = 0; fcnt_a = 0;
        for (int f = 0; f < 5; f++) begin
            a_if.i_empty = 1'b1; idle_a(); a_if.i_empty = 1'b0;
            for (int w = 0; w < 4; w++) send_a(8'(16 * f + w), 1'b1);
            idle_a();
            chk("wrap_cnt", {30'd0, a_cnt}, exp_seq[f]);
        end

        // FRAME_LEN=2 with gapped input
        for (int f = 0; f < 3; f++) begin
            b_if.i_empty = 1'b1; idle_b(); b_if.i_empty = 1'b0;
            for (int w = 0; w < 2; w++) begin
                send_b(8'(8'h30 + 2 * f + w), 1'b1);
                idle_b(); idle_b();
            end
        end
        idle_b(); idle_b();
        chk("b_write_count", wr_cnt_b, 32'd6);
        chk("b_cnt_final", {16'd0, b_cnt}, 32'd3);
        chk("b_ovf", {31'd0, b_ovf}, 32'd0);
        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
